// File: rtl/obuf_pkg.sv
// Shared state encodings, default widths and saturation bounds for the
// obuf_accum output buffer.
package obuf_pkg;

  localparam int DEF_ARRAY_M     = 8;
  localparam int DEF_RAM_SIZE    = 256;
  localparam int DEF_OUT_WIDTH   = 32;
  localparam int DEF_ACT_WIDTH   = 8;
  localparam int DEF_SHIFT_WIDTH = 5;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RUN  = 1'b1
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_RUN   = 2'd1,
    R_DRAIN = 2'd2
  } rd_state_t;

  function automatic int act_max(input int act_width);
    return (1 << (act_width - 1)) - 1;
  endfunction

  function automatic int act_min(input int act_width);
    return -(1 << (act_width - 1));
  endfunction

endpackage

// File: rtl/obuf_requant.sv
// One lane of requantisation: rounding arithmetic shift, optional ReLU,
// saturation to the signed activation range.
module obuf_requant
  import obuf_pkg::*;
#(
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int ACT_WIDTH   = DEF_ACT_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic [OUT_WIDTH-1:0]   value,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic                   relu,
  output logic [ACT_WIDTH-1:0]   act
);

  localparam logic signed [OUT_WIDTH:0] SAT_HI = (OUT_WIDTH+1)'(act_max(ACT_WIDTH));
  localparam logic signed [OUT_WIDTH:0] SAT_LO = (OUT_WIDTH+1)'(act_min(ACT_WIDTH));

  // One extra bit keeps the rounding add from overflowing.
  logic signed [OUT_WIDTH:0] ext;
  logic signed [OUT_WIDTH:0] half;
  logic signed [OUT_WIDTH:0] t;

  always_comb begin
    ext  = signed'({value[OUT_WIDTH-1], value});
    half = '0;
    t    = ext;
    if (shift != '0) begin
      half = (OUT_WIDTH+1)'(1) << (shift - SHIFT_WIDTH'(1));
      t    = (ext + half) >>> shift;
    end
    if (relu && t[OUT_WIDTH]) begin
      t = '0;
    end
    if (t > SAT_HI) begin
      act = SAT_HI[ACT_WIDTH-1:0];
    end else if (t < SAT_LO) begin
      act = SAT_LO[ACT_WIDTH-1:0];
    end else begin
      act = t[ACT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/obuf_accum.sv
// Systolic output buffer: skewed column capture with optional accumulate,
// drained as requantised rows over a valid/ready stream.
module obuf_accum
  import obuf_pkg::*;
#(
  parameter int ARRAY_M     = DEF_ARRAY_M,
  parameter int RAM_SIZE    = DEF_RAM_SIZE,
  parameter int ADDR_WIDTH  = $clog2(RAM_SIZE),
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int ACT_WIDTH   = DEF_ACT_WIDTH,
  parameter int ROW_WIDTH   = ADDR_WIDTH + 1,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [$clog2(ARRAY_M):0]       num_cols,
  input  logic                           wr_start,
  input  logic [ADDR_WIDTH-1:0]          wr_base,
  input  logic [ROW_WIDTH-1:0]           wr_rows,
  input  logic                           wr_accum,
  input  logic [ARRAY_M*OUT_WIDTH-1:0]   data_in,
  output logic                           wr_busy,
  output logic                           wr_done,
  input  logic                           rd_start,
  input  logic [ADDR_WIDTH-1:0]          rd_base,
  input  logic [ROW_WIDTH-1:0]           rd_len,
  input  logic [SHIFT_WIDTH-1:0]         rq_shift,
  input  logic                           rq_relu,
  output logic                           rd_busy,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ARRAY_M*ACT_WIDTH-1:0]   out_data
);

  localparam int COL_WIDTH = $clog2(ARRAY_M) + 1;
  localparam int CNT_WIDTH = ROW_WIDTH + 1;

  // Write sequencer
  wr_state_t              wr_state, wr_state_nxt;
  logic [ADDR_WIDTH-1:0]  wr_base_q;
  logic [ROW_WIDTH-1:0]   wr_rows_q;
  logic                   wr_accum_q;
  logic [COL_WIDTH-1:0]   wr_cols_q;
  logic [CNT_WIDTH-1:0]   wr_cnt;
  logic [CNT_WIDTH-1:0]   wr_last_cnt;
  logic                   wr_launch;
  logic                   wr_last;

  assign wr_last_cnt = CNT_WIDTH'(wr_rows_q) + CNT_WIDTH'(wr_cols_q) - CNT_WIDTH'(2);
  assign wr_busy     = (wr_state == W_RUN);

  always_comb begin
    wr_state_nxt = wr_state;
    wr_launch    = 1'b0;
    wr_last      = 1'b0;
    case (wr_state)
      W_IDLE: if (wr_start) begin
        wr_launch    = 1'b1;
        wr_state_nxt = W_RUN;
      end
      W_RUN: if (wr_cnt == wr_last_cnt) begin
        wr_last      = 1'b1;
        wr_state_nxt = W_IDLE;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wr_state <= W_IDLE;
    else        wr_state <= wr_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_base_q  <= '0;
      wr_rows_q  <= '0;
      wr_accum_q <= 1'b0;
      wr_cols_q  <= '0;
      wr_cnt     <= '0;
      wr_done    <= 1'b0;
    end else begin
      wr_done <= wr_last;
      if (wr_launch) begin
        wr_base_q  <= wr_base;
        wr_rows_q  <= wr_rows;
        wr_accum_q <= wr_accum;
        wr_cols_q  <= num_cols;
        wr_cnt     <= '0;
      end else if (wr_state == W_RUN) begin
        wr_cnt <= wr_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Read sequencer; the first row is fetched in the rd_start cycle itself
  rd_state_t              rd_state, rd_state_nxt;
  logic [ADDR_WIDTH-1:0]  rd_base_q;
  logic [ROW_WIDTH-1:0]   rd_len_q;
  logic [ROW_WIDTH-1:0]   rd_idx;
  logic [SHIFT_WIDTH-1:0] rd_shift_q;
  logic                   rd_relu_q;
  logic [COL_WIDTH-1:0]   rd_cols_q;
  logic                   rd_launch;
  logic                   rd_load;
  logic                   rd_accept;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [SHIFT_WIDTH-1:0] shift_sel;
  logic                   relu_sel;
  logic [COL_WIDTH-1:0]   cols_sel;
  logic [ARRAY_M*ACT_WIDTH-1:0] rq_row;

  assign rd_busy   = (rd_state != R_IDLE);
  assign rd_accept = out_valid && out_ready;

  always_comb begin
    rd_state_nxt = rd_state;
    rd_launch    = 1'b0;
    rd_load      = 1'b0;
    rd_addr      = rd_base_q + rd_idx[ADDR_WIDTH-1:0];
    shift_sel    = rd_shift_q;
    relu_sel     = rd_relu_q;
    cols_sel     = rd_cols_q;
    case (rd_state)
      R_IDLE: if (rd_start && !wr_busy) begin
        rd_launch    = 1'b1;
        rd_load      = 1'b1;
        rd_addr      = rd_base;
        shift_sel    = rq_shift;
        relu_sel     = rq_relu;
        cols_sel     = num_cols;
        rd_state_nxt = (rd_len == ROW_WIDTH'(1)) ? R_DRAIN : R_RUN;
      end
      R_RUN: if (!out_valid || out_ready) begin
        rd_load = 1'b1;
        if (rd_idx == rd_len_q - ROW_WIDTH'(1)) rd_state_nxt = R_DRAIN;
      end
      R_DRAIN: if (rd_accept) rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_state <= R_IDLE;
    else        rd_state <= rd_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_base_q  <= '0;
      rd_len_q   <= '0;
      rd_idx     <= '0;
      rd_shift_q <= '0;
      rd_relu_q  <= 1'b0;
      rd_cols_q  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      if (rd_launch) begin
        rd_base_q  <= rd_base;
        rd_len_q   <= rd_len;
        rd_shift_q <= rq_shift;
        rd_relu_q  <= rq_relu;
        rd_cols_q  <= num_cols;
        rd_idx     <= ROW_WIDTH'(1);
      end else if (rd_load) begin
        rd_idx <= rd_idx + ROW_WIDTH'(1);
      end
      if (rd_load) begin
        out_valid <= 1'b1;
        out_data  <= rq_row;
      end else if (rd_accept) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Column banks: lane m trails lane 0 by m cycles of the write counter
  for (genvar m = 0; m < ARRAY_M; m++) begin : g_lane
    logic [OUT_WIDTH-1:0]  bank [RAM_SIZE];
    logic [CNT_WIDTH-1:0]  lane_off;
    logic                  lane_we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [OUT_WIDTH-1:0]  din;
    logic [OUT_WIDTH-1:0]  wdata;
    logic [ACT_WIDTH-1:0]  act;

    assign lane_off = wr_cnt - CNT_WIDTH'(m);
    assign lane_we  = wr_busy && (wr_cnt >= CNT_WIDTH'(m)) &&
                      (lane_off < CNT_WIDTH'(wr_rows_q)) && (COL_WIDTH'(m) < wr_cols_q);
    assign waddr    = wr_base_q + lane_off[ADDR_WIDTH-1:0];
    assign din      = data_in[m*OUT_WIDTH +: OUT_WIDTH];
    assign wdata    = wr_accum_q ? (bank[waddr] + din) : din;

    always_ff @(posedge clk) begin
      if (lane_we) bank[waddr] <= wdata;
    end

    obuf_requant #(
      .OUT_WIDTH  (OUT_WIDTH),
      .ACT_WIDTH  (ACT_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_rq (
      .value(bank[rd_addr]),
      .shift(shift_sel),
      .relu (relu_sel),
      .act  (act)
    );

    assign rq_row[m*ACT_WIDTH +: ACT_WIDTH] = (COL_WIDTH'(m) < cols_sel) ? act : '0;
  end

endmodule
